mac_reg_bank: RTL and testbench
===============================

# mac_reg_bank

Parametrised multi-channel accumulator register bank for the MAC unit. Each channel holds a signed accumulator behind a load/hold/accumulate/subtract input mux with synchronous clear. A valid/ready write port updates one channel per cycle. A dump command streams every channel out in order over a valid/ready read port.

## Interface
- `WIDTH`, 8, input operand width (signed)
- `ACC_WIDTH`, 12, accumulator width (signed); must be ≥ WIDTH+1
- `CHANNELS`, 4, number of accumulators; must be ≥ 2
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `clr`  in  1  synchronous clear of all accumulators and flags
- `in_valid`  in  1  write request
- `in_ready`  out  1  write accepted when high with in_valid
- `in_ch`  in  $clog2(CHANNELS)  target channel
- `in_mode`  in  2  00 hold, 01 load, 10 accumulate, 11 subtract
- `in_data`  in  WIDTH  signed operand
- `dump`  in  1  start readout of all channels
- `busy`  out  1  readout in progress
- `out_valid`  out  1  out_data/out_ch valid
- `out_ready`  in  1  consumer accepts current word
- `out_ch`  out  $clog2(CHANNELS)  channel being presented
- `out_data`  out  ACC_WIDTH  accumulator value
- `sat_flag`  out  CHANNELS  sticky per-channel saturation flag

## Operation
- FSM states: IDLE and DUMP. `busy` is high in DUMP. `in_ready` = !busy.
- A write fires when `in_valid && in_ready`. Only channel `in_ch` updates. The operand is sign-extended to ACC_WIDTH.
  - hold: no change
  - load: acc = sext(in_data)
  - accumulate: acc = acc + sext
  - subtract: acc = acc − sext
- If `in_ch` ≥ CHANNELS, the handshake completes and no state changes.
- `clr` acts only in IDLE. It zeroes all accumulators and `sat_flag`. When `clr` and a write occur in the same cycle, `clr` wins: the write is discarded but the handshake still completes. `clr` is ignored in DUMP.
- If `dump` is high in IDLE, the bank moves to DUMP with `out_ch` = 0. A write in the same cycle lands first, so the readout sees post-write values.
- In DUMP, `out_data` is the registered value of channel `out_ch`. It is stable while `out_valid && !out_ready`.
- Each `out_valid && out_ready` advances `out_ch` by one. The handshake on channel CHANNELS−1 returns the FSM to IDLE. Accumulators are not modified by dump.
- `dump` is ignored while busy.
- `rst`, including mid-dump: all accumulators become 0 and the FSM goes to IDLE.
- Reset values of the outputs:
  - `busy` 0, `in_ready` 1, `out_valid` 0
  - `out_ch` 0, `out_data` 0
  - `sat_flag` 0

## Timing
- Write latency is 1 cycle. The new accumulator value is visible at the edge after the handshake.
- Back-to-back writes, including repeated writes to the same channel, are sustained at 1 per cycle.
- `dump` is sampled at edge t. At t+1, `busy`, `out_valid` and `out_ch` = 0 are all set.
- Each read handshake at edge u presents the next channel from u+1.
- The last handshake at edge u drops `busy` and `out_valid` from u+1. `in_ready` is 1 from u+1.
- With `out_ready` held high, the full dump takes CHANNELS cycles.

## Configuration
- `MAC_REG_SATURATE_EN` defined:
  - accumulate and subtract clamp to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]
  - the target channel's `sat_flag` bit sets on any clamp and stays set until `clr` or `rst`
  - load never saturates
- Not defined:
  - two's-complement wrap-around
  - `sat_flag` tied to 0

## Structure
- Package `mac_reg_pkg` holds:
  - the mode encodings (HOLD, LOAD, ACC, SUB) as a typedef'd enum
  - the FSM state enum
  - the sign-extension function
  - the saturating add function
- Sub-module `mac_acc_lane` contains one channel's accumulator, input mux, clear and saturation logic. The top level generates CHANNELS instances.

## Test plan
- Reset, then load ch2 with −5, then dump with `out_ready`=1 → words (0,0), (1,0), (2,−5), (3,0) on consecutive cycles; `busy` drops after 4 cycles.
- Accumulate 127 into ch1 seventeen times → with the macro: 2047 and `sat_flag`[1]=1. Without the macro: −1937 and `sat_flag`=0.
- Set `clr` and a load of 9 to ch0 in the same cycle → ch0 reads 0 and `in_ready` stayed 1.
- Start a dump, hold `out_ready`=0 for 3 cycles on ch1 → `out_data`/`out_ch` stable. Assert `in_valid` → `in_ready`=0 and no update. Assert `clr` → ignored.
- Load ch3 with 7 in the same cycle as `dump` → ch3 reads 7 in the dump. Write to `in_ch`=3 of a 3-channel build → no state change.
- Assert `rst` mid-dump at ch2 → next cycle `busy`=0, `out_valid`=0, all channels read 0 on the next dump.

Source files
------------

// File: rtl/mac_reg_pkg.sv
// Shared types and arithmetic helpers for the MAC accumulator register bank.
// The helpers work on a 64-bit carrier, so ACC_WIDTH must be at most 63.
package mac_reg_pkg;

  localparam int unsigned MaxW = 64;

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeLoad = 2'b01,
    ModeAcc  = 2'b10,
    ModeSub  = 2'b11
  } mode_e;

  typedef enum logic {
    StIdle,
    StDump
  } state_e;

  typedef struct packed {
    logic signed [MaxW-1:0] value;
    logic                   clamped;
  } sat_res_t;

  // Sign-extend the low w bits of v to the full carrier width.
  function automatic logic signed [MaxW-1:0] sext(input logic [MaxW-1:0] v, input int unsigned w);
    logic [MaxW-1:0] sh;
    sh = v << (MaxW - w);
    return $signed(sh) >>> (MaxW - w);
  endfunction

  // Add two w-bit signed values and clamp the sum to the signed w-bit range.
  function automatic sat_res_t sat_add(input logic signed [MaxW-1:0] a,
                                       input logic signed [MaxW-1:0] b,
                                       input int unsigned            w);
    logic signed [MaxW-1:0] sum;
    logic signed [MaxW-1:0] hi;
    logic signed [MaxW-1:0] lo;
    sat_res_t               r;
    sum       = a + b;
    hi        = $signed((MaxW'(1) << (w - 1)) - MaxW'(1));
    lo        = ~hi;
    r.clamped = 1'b1;
    if (sum > hi) begin
      r.value = hi;
    end else if (sum < lo) begin
      r.value = lo;
    end else begin
      r.value   = sum;
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_reg_bank_if.sv
// Write and read handshake ports of the MAC accumulator register bank.
interface mac_reg_bank_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned CHANNELS  = 4
);
  localparam int unsigned ChW = $clog2(CHANNELS);

  logic                 in_valid;
  logic                 in_ready;
  logic [ChW-1:0]       in_ch;
  logic [1:0]           in_mode;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ChW-1:0]       out_ch;
  logic [ACC_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_ch, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  in_valid, in_ch, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/mac_acc_lane.sv
// One accumulator channel: input mux, synchronous clear, optional saturation.
// Saturation is enabled by defining MAC_REG_SATURATE_EN; otherwise arithmetic wraps.
module mac_acc_lane
  import mac_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  mode_e                mode_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 sat_o
);

  logic [ACC_WIDTH-1:0]   acc_d, acc_q;
  logic signed [MaxW-1:0] operand;

  assign operand = sext(MaxW'(data_i), WIDTH);
  assign acc_o   = acc_q;

`ifdef MAC_REG_SATURATE_EN
  logic     sat_d, sat_q;
  sat_res_t res;

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    res   = sat_add(sext(MaxW'(acc_q), ACC_WIDTH), (mode_i == ModeSub) ? -operand : operand,
                    ACC_WIDTH);
    if (clr_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (we_i) begin
      unique case (mode_i)
        ModeLoad: acc_d = ACC_WIDTH'(operand);
        ModeAcc, ModeSub: begin
          acc_d = ACC_WIDTH'(res.value);
          sat_d = sat_q | res.clamped;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (we_i) begin
      unique case (mode_i)
        ModeLoad: acc_d = ACC_WIDTH'(operand);
        ModeAcc:  acc_d = acc_q + ACC_WIDTH'(operand);
        ModeSub:  acc_d = acc_q - ACC_WIDTH'(operand);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/mac_reg_bank.sv
// Multi-channel signed accumulator bank with a per-channel write port and a streaming dump.
// Optional saturation via MAC_REG_SATURATE_EN (see mac_acc_lane).
module mac_reg_bank
  import mac_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned CHANNELS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                dump,
  output logic                busy,
  output logic [CHANNELS-1:0] sat_flag,
  mac_reg_bank_if.slave       bus
);

  localparam int unsigned ChW = $clog2(CHANNELS);

  state_e               state_d, state_q;
  logic [ChW-1:0]       out_ch_d, out_ch_q;
  logic [ACC_WIDTH-1:0] acc [CHANNELS];
  logic                 in_fire;
  logic                 clr_eff;
  mode_e                mode;

  assign busy          = (state_q == StDump);
  assign bus.in_ready  = ~busy;
  assign bus.out_valid = busy;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = acc[out_ch_q];

  assign in_fire = bus.in_valid & ~busy;
  assign clr_eff = clr & ~busy;
  assign mode    = mode_e'(bus.in_mode);

  // Out-of-range channel numbers match no lane, so the handshake completes with no effect.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    mac_acc_lane #(
      .WIDTH    (WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr_eff),
      .we_i  (in_fire && (bus.in_ch == ChW'(i))),
      .mode_i(mode),
      .data_i(bus.in_data),
      .acc_o (acc[i]),
      .sat_o (sat_flag[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    out_ch_d = out_ch_q;
    unique case (state_q)
      StIdle: begin
        if (dump) begin
          state_d  = StDump;
          out_ch_d = '0;
        end
      end
      StDump: begin
        if (bus.out_ready) begin
          if (out_ch_q == ChW'(CHANNELS - 1)) begin
            state_d  = StIdle;
            out_ch_d = '0;
          end else begin
            out_ch_d = out_ch_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      out_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      out_ch_q <= out_ch_d;
    end
  end

endmodule

// File: tb/tb_mac_reg_bank.sv
// Directed bench for mac_reg_bank: a 4-channel bank plus a 3-channel bank for range checks.
module tb_mac_reg_bank;
  import mac_reg_pkg::*;

`ifdef MAC_REG_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, dump, busy;
  logic [3:0] sat_flag;
  logic       clr3, dump3, busy3;
  logic [2:0] sat3;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  mac_reg_bank_if #(.WIDTH(8), .ACC_WIDTH(12), .CHANNELS(4)) b ();
  mac_reg_bank_if #(.WIDTH(8), .ACC_WIDTH(12), .CHANNELS(3)) b3 ();

  mac_reg_bank #(.WIDTH(8), .ACC_WIDTH(12), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .dump(dump), .busy(busy), .sat_flag(sat_flag), .bus(b)
  );

  mac_reg_bank #(.WIDTH(8), .ACC_WIDTH(12), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .clr(clr3), .dump(dump3), .busy(busy3), .sat_flag(sat3), .bus(b3)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input mode_e mode, input int data);
    b.in_valid = 1'b1;
    b.in_ch    = 2'(ch);
    b.in_mode  = mode;
    b.in_data  = 8'(data);
    step();
    b.in_valid = 1'b0;
  endtask

  task automatic wr3(input int ch, input mode_e mode, input int data);
    b3.in_valid = 1'b1;
    b3.in_ch    = 2'(ch);
    b3.in_mode  = mode;
    b3.in_data  = 8'(data);
    check("ch3_in_ready", b3.in_ready, 1);
    step();
    b3.in_valid = 1'b0;
  endtask

  // Any write already on the port lands in the same cycle as dump.
  task automatic run_dump(input string tag, input int e0, input int e1, input int e2,
                          input int e3);
    int exp_v[4];
    exp_v       = '{e0, e1, e2, e3};
    dump        = 1'b1;
    b.out_ready = 1'b1;
    step();
    dump       = 1'b0;
    b.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_valid"}, b.out_valid, 1);
      check({tag, "_ch"}, b.out_ch, k);
      check({tag, "_data"}, $signed(b.out_data), exp_v[k]);
      step();
    end
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid_end"}, b.out_valid, 0);
    check({tag, "_ready_end"}, b.in_ready, 1);
  endtask

  initial begin
    int acc17, sub16;
    acc17 = SatEn ? 2047 : -1937;
    sub16 = SatEn ? -2048 : 1936;

    rst = 1'b1; clr = 1'b0; dump = 1'b0; clr3 = 1'b0; dump3 = 1'b0;
    b.in_valid = 1'b0; b.in_ch = '0; b.in_mode = '0; b.in_data = '0; b.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_ch = '0; b3.in_mode = '0; b3.in_data = '0; b3.out_ready = 1'b0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_in_ready", b.in_ready, 1);
    check("rst_out_valid", b.out_valid, 0);
    check("rst_out_ch", b.out_ch, 0);
    check("rst_out_data", b.out_data, 0);
    check("rst_sat", sat_flag, 0);
    rst = 1'b0;

    // Load a negative value and stream everything out.
    wr(2, ModeLoad, -5);
    run_dump("t1", 0, 0, -5, 0);

    // Positive overflow on ch1, negative overflow on ch3, hold and subtract on others.
    repeat (17) wr(1, ModeAcc, 127);
    check("t2_sat_ch1", sat_flag, SatEn ? 4'b0010 : 4'b0000);
    wr(3, ModeLoad, -128);
    repeat (16) wr(3, ModeSub, 127);
    check("t2_sat_ch3", sat_flag, SatEn ? 4'b1010 : 4'b0000);
    wr(2, ModeHold, 55);
    wr(0, ModeLoad, 100);
    wr(0, ModeSub, 30);
    run_dump("t2", 70, acc17, -5, sub16);

    // Clear beats a simultaneous write.
    clr        = 1'b1;
    b.in_valid = 1'b1; b.in_ch = 2'd0; b.in_mode = ModeLoad; b.in_data = 8'd9;
    #1;
    check("t3_in_ready", b.in_ready, 1);
    step();
    clr = 1'b0; b.in_valid = 1'b0;
    check("t3_sat", sat_flag, 0);
    run_dump("t3", 0, 0, 0, 0);

    // Back-pressure on ch1 while writes and clear are attempted.
    wr(1, ModeLoad, 33);
    dump = 1'b1; b.out_ready = 1'b1;
    step();
    dump = 1'b0;
    check("t4_ch0", b.out_ch, 0);
    step();
    b.out_ready = 1'b0;
    b.in_valid = 1'b1; b.in_ch = 2'd1; b.in_mode = ModeLoad; b.in_data = 8'd5;
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_ch", b.out_ch, 1);
      check("t4_hold_data", $signed(b.out_data), 33);
      check("t4_in_ready", b.in_ready, 0);
      step();
    end
    b.in_valid = 1'b0; clr = 1'b0; b.out_ready = 1'b1;
    check("t4_ch1_after", $signed(b.out_data), 33);
    step();
    check("t4_ch2", b.out_ch, 2);
    step();
    check("t4_ch3", b.out_ch, 3);
    step();
    check("t4_done", busy, 0);

    // Write coinciding with dump is visible in the readout.
    b.in_valid = 1'b1; b.in_ch = 2'd3; b.in_mode = ModeLoad; b.in_data = 8'd7;
    run_dump("t5", 0, 33, 0, 7);

    // Reset in the middle of a dump.
    dump = 1'b1; b.out_ready = 1'b1;
    step();
    dump = 1'b0;
    step();
    step();
    check("t6_at_ch2", b.out_ch, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_valid", b.out_valid, 0);
    check("t6_in_ready", b.in_ready, 1);
    run_dump("t6", 0, 0, 0, 0);

    // Three-channel build: channel index 3 must be ignored.
    wr3(0, ModeLoad, 4);
    wr3(2, ModeLoad, 11);
    wr3(3, ModeLoad, 99);
    wr3(3, ModeAcc, 1);
    dump3 = 1'b1; b3.out_ready = 1'b1;
    step();
    dump3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("c3_ch", b3.out_ch, k);
      check("c3_data", $signed(b3.out_data), (k == 0) ? 4 : ((k == 2) ? 11 : 0));
      step();
    end
    check("c3_busy_end", busy3, 0);
    check("c3_sat", sat3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
